// File: rtl/bcd_to_number_if.sv
// bcd_to_number_if: input digit transfer and result transfer of the BCD
// converter, each with its own valid/ready pair.
//   master: digit source / result sink (testbench or entry logic)
//   slave : the converter
interface bcd_to_number_if #(
  parameter int NDIG  = 6,
  parameter int OUT_W = 20
);
  logic [4*NDIG-1:0] bcd;
  logic              in_valid;
  logic              in_ready;
  logic [OUT_W-1:0]  num;
  logic              out_valid;
  logic              out_ready;
  logic              err;

  modport master (
    output bcd, in_valid, out_ready,
    input  in_ready, num, out_valid, err
  );

  modport slave (
    input  bcd, in_valid, out_ready,
    output in_ready, num, out_valid, err
  );
endinterface

// File: rtl/bcd_to_number.sv
// bcd_to_number: packed BCD digits -> binary, one digit per clock,
// most-significant digit first, via acc = acc*10 + digit.
// Flow: IDLE (accept) -> CONV (NDIG cycles) -> DONE (hold until out_ready).
// Optional digit check: define BCD_TO_NUMBER_DIGIT_CHECK_EN to flag digits
// > 9 (result forced to 0, err = 1). Without it err is tied low and digits
// 10..15 are folded in as plain binary values.
// OUT_W must be >= 4 and large enough for 10^NDIG - 1.
module bcd_to_number #(
  parameter int NDIG  = 6,
  parameter int OUT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  bcd_to_number_if.slave    bus
);
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            state;
  logic [4*NDIG-1:0] sh;
  logic [OUT_W-1:0]  acc;
  logic [CW-1:0]     cnt;
  logic [OUT_W-1:0]  num;
  logic              in_ready;
  logic              out_valid;
  logic [3:0]        digit;
  logic [OUT_W-1:0]  acc_nxt;

  // Top nibble of the shift register is always the next digit to fold in.
  assign digit   = sh[4*NDIG-1 -: 4];
  assign acc_nxt = (acc << 3) + (acc << 1) + {{(OUT_W-4){1'b0}}, digit};

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.num       = num;

`ifdef BCD_TO_NUMBER_DIGIT_CHECK_EN
  logic err_flag;
  logic err_r;
  logic bad;
  // Running error including the digit being folded this cycle, so the last
  // digit is covered in the same edge that enters DONE.
  assign bad     = (digit > 4'd9);
  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  // Control FSM plus datapath; all handshake outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      num       <= '0;
      acc       <= '0;
      cnt       <= '0;
      sh        <= '0;
`ifdef BCD_TO_NUMBER_DIGIT_CHECK_EN
      err_flag  <= 1'b0;
      err_r     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // in_ready is high for the whole of IDLE, so valid alone accepts.
          if (bus.in_valid) begin
            sh       <= bus.bcd;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CONV;
`ifdef BCD_TO_NUMBER_DIGIT_CHECK_EN
            err_flag <= 1'b0;
            err_r    <= 1'b0;
`endif
          end
        end
        CONV: begin
          acc <= acc_nxt;
          sh  <= sh << 4;
          cnt <= cnt + 1'b1;
`ifdef BCD_TO_NUMBER_DIGIT_CHECK_EN
          err_flag <= err_flag | bad;
`endif
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef BCD_TO_NUMBER_DIGIT_CHECK_EN
            num   <= (err_flag | bad) ? '0 : acc_nxt;
            err_r <= err_flag | bad;
`else
            num   <= acc_nxt;
`endif
          end
        end
        DONE: begin
          // Result and err hold until consumed; num keeps its value in IDLE.
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_number.sv
// tb_bcd_to_number: directed tests of the BCD converter (NDIG=6, OUT_W=20).
// Inputs are driven and outputs sampled on the falling edge.
module tb_bcd_to_number;
  localparam int NDIG  = 6;
  localparam int OUT_W = 20;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bcd_to_number_if #(.NDIG(NDIG), .OUT_W(OUT_W)) bus ();

  bcd_to_number #(.NDIG(NDIG), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full clock: through the rising edge to the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept one value and wait (bounded) until out_valid is seen.
  // lat = rising edges after the accept edge until out_valid is visible.
  task automatic run(input logic [23:0] b, output logic [19:0] n,
                     output logic e, output int lat);
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin step(); w++; end
    bus.bcd      = b;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin step(); lat++; end
    n = bus.num;
    e = bus.err;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.bcd       = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.num !== 20'd0) begin failures++; $display("FAIL reset_num got=%0d exp=0", bus.num); end
    checks++;
    if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
  endtask

  // 0x123456 with out_ready held: 6 CONV edges, one-cycle valid pulse.
  task automatic test_basic();
    logic [19:0] n;
    logic        e;
    int          lat;
    bus.out_ready = 1'b1;
    run(24'h123456, n, e, lat);
    checks++;
    if (lat !== 6) begin failures++; $display("FAIL basic_latency got=%0d exp=6", lat); end
    checks++;
    if (n !== 20'd123456) begin failures++; $display("FAIL basic_num got=%0d exp=123456", n); end
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", e); end
    checks++;
    if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL basic_ready_in_done got=%b exp=0", bus.in_ready); end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_ready_after got=%b exp=1", bus.in_ready); end
  endtask

  // 0x999999 then 0x000000 with in_valid held high: accepts 8 edges apart.
  task automatic test_back_to_back();
    logic [19:0] n1, n2;
    int          gap;
    int          w;
    n1 = '1;
    n2 = '1;
    bus.out_ready = 1'b1;
    bus.bcd       = 24'h999999;
    bus.in_valid  = 1'b1;
    step();                       // first accept edge
    bus.bcd = 24'h000000;
    gap = 1;
    while (!bus.in_ready && gap < 20) begin
      if (bus.out_valid) n1 = bus.num;
      step();
      gap++;
    end
    step();                       // second accept edge
    bus.in_valid = 1'b0;
    checks++;
    if (gap !== 8) begin failures++; $display("FAIL b2b_spacing got=%0d exp=8", gap); end
    checks++;
    if (n1 !== 20'd999999) begin failures++; $display("FAIL b2b_num_999999 got=%0d exp=999999", n1); end
    w = 0;
    while (!bus.out_valid && w < 20) begin step(); w++; end
    n2 = bus.num;
    checks++;
    if (n2 !== 20'd0 || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_num_zero got=%0d valid=%b exp=0 valid=1", n2, bus.out_valid);
    end
    step();
  endtask

  // Result held for 5 cycles with out_ready low while new input is offered.
  task automatic test_backpressure();
    logic [19:0] n;
    logic        e;
    int          lat;
    bit          held;
    bus.out_ready = 1'b0;
    run(24'h000321, n, e, lat);
    checks++;
    if (n !== 20'd321 || lat !== 6) begin failures++; $display("FAIL bp_first got=%0d lat=%0d exp=321 lat=6", n, lat); end
    bus.bcd      = 24'h999999;
    bus.in_valid = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.out_valid !== 1'b1 || bus.num !== 20'd321 || bus.in_ready !== 1'b0) held = 1'b0;
    end
    checks++;
    if (held !== 1'b1) begin failures++; $display("FAIL bp_hold got=0 exp=1 (valid=%b num=%0d ready=%b)", bus.out_valid, bus.num, bus.in_ready); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready);
    end
    step(); step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.num !== 20'd321) begin
      failures++; $display("FAIL bp_ignored_input got valid=%b num=%0d exp valid=0 num=321", bus.out_valid, bus.num);
    end
  endtask

  // Reset three edges after accepting 0x654321, then a fresh 0x000042.
  task automatic test_reset_mid();
    logic [19:0] n;
    logic        e;
    int          lat;
    bit          pulsed;
    bus.out_ready = 1'b1;
    bus.bcd       = 24'h654321;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.num !== 20'd0) begin
      failures++; $display("FAIL rstmid_state got ready=%b valid=%b num=%0d exp 1 0 0", bus.in_ready, bus.out_valid, bus.num);
    end
    pulsed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_valid) pulsed = 1'b1;
    end
    checks++;
    if (pulsed !== 1'b0) begin failures++; $display("FAIL rstmid_no_valid got=1 exp=0"); end
    run(24'h000042, n, e, lat);
    checks++;
    if (n !== 20'd42 || lat !== 6) begin failures++; $display("FAIL rstmid_fresh got=%0d lat=%0d exp=42 lat=6", n, lat); end
    step();
  endtask

  // Non-BCD digit in the third position.
  task automatic test_bad_digit();
    logic [19:0] n;
    logic        e;
    int          lat;
    bus.out_ready = 1'b1;
    run(24'h12A456, n, e, lat);
`ifdef BCD_TO_NUMBER_DIGIT_CHECK_EN
    checks++;
    if (n !== 20'd0 || e !== 1'b1) begin failures++; $display("FAIL bad_digit got num=%0d err=%b exp num=0 err=1", n, e); end
`else
    checks++;
    if (n !== 20'd130456 || e !== 1'b0) begin failures++; $display("FAIL bad_digit got num=%0d err=%b exp num=130456 err=0", n, e); end
`endif
    step();
    // A clean value afterwards must report no error.
    run(24'h000009, n, e, lat);
    checks++;
    if (n !== 20'd9 || e !== 1'b0) begin failures++; $display("FAIL err_clears got num=%0d err=%b exp num=9 err=0", n, e); end
    step();
  endtask

  // bcd changes to all-ones one cycle after acceptance.
  task automatic test_input_change();
    int w;
    bus.out_ready = 1'b1;
    bus.bcd       = 24'h000777;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    bus.bcd = 24'hFFFFFF;
    w = 0;
    while (!bus.out_valid && w < 20) begin step(); w++; end
    checks++;
    if (bus.num !== 20'd777 || bus.out_valid !== 1'b1) begin
      failures++; $display("FAIL input_change got num=%0d valid=%b exp num=777 valid=1", bus.num, bus.out_valid);
    end
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_bad_digit();
    test_input_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
